// File: rtl/alu3_action_issuer.sv
// alu3_action_issuer
//
// Pairs ALU action requests with metadata beats from the lookup stage.
// Each side has its own FIFO. Whenever both FIFO heads are present they
// pop together, and the pair is registered onto the outputs one cycle later.
//
// Optional feature: define ALU3_ISSUER_STATS_EN to enable the
// meta_drop_cnt / pair_cnt statistics counters. Without it both read 0.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   flush                      synchronous clear of both FIFOs
//   req_opcode/portmap/valid   action request, accepted when req_ready=1
//   req_ready                  registered: action FIFO not full
//   comp_meta_data_in/valid_in metadata beat (no backpressure)
//   action_out/valid_out       encoded action word to the ALU
//   comp_meta_data_out/valid   metadata paired with action_out
//   meta_drop_cnt              metadata beats dropped on a full FIFO
//   pair_cnt                   number of pairs issued
module alu3_action_issuer #(
  parameter int ACTION_LEN = 25,
  parameter int META_LEN   = 256,
  parameter int COMP_LEN   = 100,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [3:0]                   req_opcode,
  input  logic [7:0]                   req_portmap,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [META_LEN+COMP_LEN-1:0] comp_meta_data_in,
  input  logic                         comp_meta_data_valid_in,
  output logic [ACTION_LEN-1:0]        action_out,
  output logic                         action_valid_out,
  output logic [META_LEN+COMP_LEN-1:0] comp_meta_data_out,
  output logic                         comp_meta_data_valid_out,
  output logic [15:0]                  meta_drop_cnt,
  output logic [15:0]                  pair_cnt
);

  localparam int MW = META_LEN + COMP_LEN;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [ACTION_LEN-1:0] actMem  [FIFO_DEPTH];
  logic [MW-1:0]         metaMem [FIFO_DEPTH];

  logic [PW-1:0]         actWr_q, actRd_q, metaWr_q, metaRd_q;
  logic [CW-1:0]         actCount_q, actCount_d, metaCount_q, metaCount_d;
  logic                  reqReady_q;
  logic                  validOut_q;
  logic [ACTION_LEN-1:0] actionOut_q;
  logic [MW-1:0]         metaOut_q;

  logic                  pushAct, pushMeta, popPair;
  logic [24:0]           actionCode;
  logic [ACTION_LEN-1:0] encAction;

  // Encode the request into the 25-bit action layout
  // {opcode, portmap, flag, 12'b0}. Unknown opcodes become a no-op word.
  always_comb begin
    actionCode = '0;
    case (req_opcode)
      4'b1100: actionCode = {4'b1100, req_portmap, 1'b0, 12'h000};
      4'b1101: actionCode = {4'b1101, 8'h00, 1'b1, 12'h000};
      default: actionCode = '0;
    endcase
    encAction = ACTION_LEN'(actionCode);
  end

  // Push/pop decisions and next occupancy. A flush overrides everything:
  // it blocks pushes and pops and forces both FIFOs empty. A full metadata
  // FIFO can still take a beat when its head leaves in the same cycle.
  always_comb begin
    popPair  = (actCount_q != '0) && (metaCount_q != '0) && !flush;
    pushAct  = req_valid && reqReady_q && !flush;
    pushMeta = comp_meta_data_valid_in && !flush &&
               ((metaCount_q != DEPTH_C) || popPair);

    actCount_d = actCount_q;
    if (pushAct && !popPair)      actCount_d = actCount_q + CW'(1);
    else if (!pushAct && popPair) actCount_d = actCount_q - CW'(1);

    metaCount_d = metaCount_q;
    if (pushMeta && !popPair)      metaCount_d = metaCount_q + CW'(1);
    else if (!pushMeta && popPair) metaCount_d = metaCount_q - CW'(1);

    if (flush) begin
      actCount_d  = '0;
      metaCount_d = '0;
    end
  end

  // FIFO storage. It is not reset; the pointers and counts alone decide
  // which entries are live.
  always_ff @(posedge clk) begin
    if (pushAct)  actMem[actWr_q]   <= encAction;
    if (pushMeta) metaMem[metaWr_q] <= comp_meta_data_in;
  end

  // Pointers, occupancy and the registered output stage. req_ready is taken
  // from the next occupancy, so it shows "not full" at the start of each
  // cycle without any combinational path from the pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      actWr_q     <= '0;
      actRd_q     <= '0;
      metaWr_q    <= '0;
      metaRd_q    <= '0;
      actCount_q  <= '0;
      metaCount_q <= '0;
      reqReady_q  <= 1'b0;
      validOut_q  <= 1'b0;
      actionOut_q <= '0;
      metaOut_q   <= '0;
    end else begin
      actCount_q  <= actCount_d;
      metaCount_q <= metaCount_d;
      reqReady_q  <= (actCount_d < DEPTH_C);
      validOut_q  <= popPair;
      if (flush) begin
        actWr_q  <= '0;
        actRd_q  <= '0;
        metaWr_q <= '0;
        metaRd_q <= '0;
      end else begin
        if (pushAct)  actWr_q  <= actWr_q + PW'(1);
        if (pushMeta) metaWr_q <= metaWr_q + PW'(1);
        if (popPair) begin
          actRd_q  <= actRd_q + PW'(1);
          metaRd_q <= metaRd_q + PW'(1);
        end
      end
      if (popPair) begin
        actionOut_q <= actMem[actRd_q];
        metaOut_q   <= metaMem[metaRd_q];
      end
    end
  end

  assign req_ready                = reqReady_q;
  assign action_out               = actionOut_q;
  assign action_valid_out         = validOut_q;
  assign comp_meta_data_out       = metaOut_q;
  assign comp_meta_data_valid_out = validOut_q;

`ifdef ALU3_ISSUER_STATS_EN
  logic        metaDrop;
  logic [15:0] dropCnt_q, pairCnt_q;

  assign metaDrop = comp_meta_data_valid_in && !flush &&
                    (metaCount_q == DEPTH_C) && !popPair;

  // Saturating statistics counters. A flush leaves them alone; only
  // reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      dropCnt_q <= '0;
      pairCnt_q <= '0;
    end else begin
      if (metaDrop && (dropCnt_q != 16'hFFFF)) dropCnt_q <= dropCnt_q + 16'd1;
      if (popPair && (pairCnt_q != 16'hFFFF))  pairCnt_q <= pairCnt_q + 16'd1;
    end
  end

  assign meta_drop_cnt = dropCnt_q;
  assign pair_cnt      = pairCnt_q;
`else
  assign meta_drop_cnt = 16'h0000;
  assign pair_cnt      = 16'h0000;
`endif

endmodule

// File: tb/tb_alu3_action_issuer.sv
// tb_alu3_action_issuer
//
// Directed bench for alu3_action_issuer. It drives request/metadata
// sequences and keeps a queue-based model of the pairing behaviour. Every
// cycle the DUT outputs are compared against that model, and a few literal
// expectations are checked as well. Define ALU3_ISSUER_STATS_EN to also
// check the statistics counters against the model.
module tb_alu3_action_issuer;

  localparam int MW    = 356;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, flush, req_valid, comp_meta_data_valid_in;
  logic [3:0]    req_opcode;
  logic [7:0]    req_portmap;
  logic [MW-1:0] comp_meta_data_in;
  logic          req_ready, action_valid_out, comp_meta_data_valid_out;
  logic [24:0]   action_out;
  logic [MW-1:0] comp_meta_data_out;
  logic [15:0]   meta_drop_cnt, pair_cnt;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Model state
  logic [24:0]   actQ[$];
  logic [MW-1:0] metaQ[$];
  logic          mReady = 1'b0, mValid = 1'b0;
  logic [24:0]   mAction = '0;
  logic [MW-1:0] mMeta = '0;
  logic [15:0]   mDrop = '0, mPair = '0;
  bit            metaFull, canPop, accept;

  alu3_action_issuer dut (
    .clk                      (clk),
    .rst                      (rst),
    .flush                    (flush),
    .req_opcode               (req_opcode),
    .req_portmap              (req_portmap),
    .req_valid                (req_valid),
    .req_ready                (req_ready),
    .comp_meta_data_in        (comp_meta_data_in),
    .comp_meta_data_valid_in  (comp_meta_data_valid_in),
    .action_out               (action_out),
    .action_valid_out         (action_valid_out),
    .comp_meta_data_out       (comp_meta_data_out),
    .comp_meta_data_valid_out (comp_meta_data_valid_out),
    .meta_drop_cnt            (meta_drop_cnt),
    .pair_cnt                 (pair_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] encode(input logic [3:0] op, input logic [7:0] pm);
    if (op == 4'b1100) return {4'b1100, pm, 1'b0, 12'h000};
    if (op == 4'b1101) return {4'b1101, 8'h00, 1'b1, 12'h000};
    return 25'h0;
  endfunction

  function automatic logic [MW-1:0] metaVal(input int k);
    return {8'(k), 340'h0, 8'(k)};
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: FIFOs are plain queues. A pair pops when both
  // queues hold an entry at the start of the cycle. A metadata beat that
  // arrives on a full queue is dropped unless a pop frees a slot.
  always @(posedge clk) begin
    if (rst) begin
      actQ.delete();
      metaQ.delete();
      mReady  = 1'b0;
      mValid  = 1'b0;
      mAction = '0;
      mMeta   = '0;
      mDrop   = '0;
      mPair   = '0;
    end else if (flush) begin
      actQ.delete();
      metaQ.delete();
      mValid = 1'b0;
      mReady = 1'b1;
    end else begin
      metaFull = (metaQ.size() == DEPTH);
      canPop   = (actQ.size() > 0) && (metaQ.size() > 0);
      accept   = req_valid && mReady;
      if (canPop) begin
        mAction = actQ.pop_front();
        mMeta   = metaQ.pop_front();
        mValid  = 1'b1;
        if (mPair != 16'hFFFF) mPair++;
      end else begin
        mValid = 1'b0;
      end
      if (comp_meta_data_valid_in) begin
        if (!metaFull || canPop) metaQ.push_back(comp_meta_data_in);
        else if (mDrop != 16'hFFFF) mDrop++;
      end
      if (accept) actQ.push_back(encode(req_opcode, req_portmap));
      mReady = (actQ.size() < DEPTH);
    end
  end

  // Per-cycle comparison against the model, half a cycle after the edge
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("req_ready", 512'(req_ready), 512'(mReady));
      checkOutput("action_valid_out", 512'(action_valid_out), 512'(mValid));
      checkOutput("meta_valid_out", 512'(comp_meta_data_valid_out), 512'(mValid));
      checkOutput("action_out", 512'(action_out), 512'(mAction));
      checkOutput("comp_meta_data_out", 512'(comp_meta_data_out), 512'(mMeta));
`ifdef ALU3_ISSUER_STATS_EN
      checkOutput("meta_drop_cnt", 512'(meta_drop_cnt), 512'(mDrop));
      checkOutput("pair_cnt", 512'(pair_cnt), 512'(mPair));
`else
      checkOutput("meta_drop_cnt", 512'(meta_drop_cnt), 512'(16'h0));
      checkOutput("pair_cnt", 512'(pair_cnt), 512'(16'h0));
`endif
    end
  end

  task automatic applyStimulus(input logic r, input logic f, input logic [3:0] op,
                               input logic [7:0] pm, input logic rv,
                               input logic [MW-1:0] md, input logic mv);
    rst                     = r;
    flush                   = f;
    req_opcode              = op;
    req_portmap             = pm;
    req_valid               = rv;
    comp_meta_data_in       = md;
    comp_meta_data_valid_in = mv;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 4'h0, 8'h00, 0, '0, 0);
  endtask

  task automatic sendReq(input logic [3:0] op, input logic [7:0] pm);
    applyStimulus(0, 0, op, pm, 1, '0, 0);
  endtask

  task automatic sendMeta(input int k);
    applyStimulus(0, 0, 4'h0, 8'h00, 0, metaVal(k), 1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; comp_meta_data_valid_in = 1'b0;
    req_opcode = '0; req_portmap = '0; comp_meta_data_in = '0;

    // Reset
    applyStimulus(1, 0, 4'h0, 8'h00, 0, '0, 0);
    checkEn = 1'b1;
    applyStimulus(1, 0, 4'h0, 8'h00, 0, '0, 0);
    checkOutput("lit_reset_ready", 512'(req_ready), 512'(1'b0));
    checkOutput("lit_reset_action", 512'(action_out), 512'(25'h0));
    idle(1);
    checkOutput("lit_ready_after_release", 512'(req_ready), 512'(1'b1));

    // Opcode 1100 with portmap FF and an all-zero metadata beat together
    applyStimulus(0, 0, 4'b1100, 8'hFF, 1, '0, 1);
    idle(1);
    checkOutput("lit_021_action", 512'(action_out), 512'(25'h19FE000));
    checkOutput("lit_021_valid", 512'(action_valid_out), 512'(1'b1));
    idle(1);
    checkOutput("lit_021_one_cycle", 512'(action_valid_out), 512'(1'b0));

    // Opcode 1101, metadata three cycles later
    sendReq(4'b1101, 8'hAA);
    idle(2);
    sendMeta(1);
    checkOutput("lit_022_no_early", 512'(action_valid_out), 512'(1'b0));
    idle(1);
    checkOutput("lit_022_action", 512'(action_out), 512'(25'h1A01000));
    checkOutput("lit_022_meta", 512'(comp_meta_data_out), 512'(metaVal(1)));

    // Unknown opcode -> no-op word but still a valid pair
    applyStimulus(0, 0, 4'b0011, 8'h3C, 1, metaVal(2), 1);
    idle(1);
    checkOutput("lit_023_action", 512'(action_out), 512'(25'h0));
    checkOutput("lit_023_valid", 512'(comp_meta_data_valid_out), 512'(1'b1));

    // Five metadata beats into a depth-4 FIFO, then five requests
    for (int k = 10; k < 15; k++) sendMeta(k);
    for (int p = 1; p <= 5; p++) sendReq(4'b1100, 8'(p));
    checkOutput("lit_024_last_action", 512'(action_out), 512'(25'h1808000));
    checkOutput("lit_024_last_meta", 512'(comp_meta_data_out), 512'(metaVal(13)));
`ifdef ALU3_ISSUER_STATS_EN
    checkOutput("lit_024_drop_cnt", 512'(meta_drop_cnt), 512'(16'd1));
    checkOutput("lit_024_pair_cnt", 512'(pair_cnt), 512'(16'd7));
`endif
    idle(1);

    // Fill the action FIFO (one request still queued), then flush
    for (int p = 0; p < 3; p++) sendReq(4'b1101, 8'h00);
    checkOutput("lit_025_full_ready", 512'(req_ready), 512'(1'b0));
    applyStimulus(0, 1, 4'b1100, 8'h11, 1, metaVal(19), 1);
    checkOutput("lit_025_flush_ready", 512'(req_ready), 512'(1'b1));
    checkOutput("lit_025_flush_valid", 512'(action_valid_out), 512'(1'b0));
    sendMeta(20);
    idle(2);
    sendReq(4'b1100, 8'h5A);
    idle(2);

    // Full metadata FIFO: drop without a pop, accept alongside a pop
    for (int k = 30; k < 34; k++) sendMeta(k);
    applyStimulus(0, 0, 4'b1100, 8'h77, 1, metaVal(34), 1);
    sendMeta(35);
    idle(1);

    // Reset with work pending
    sendReq(4'b1101, 8'h00);
    sendReq(4'b1100, 8'h42);
    applyStimulus(1, 0, 4'b1100, 8'h99, 1, metaVal(40), 1);
    checkOutput("lit_026_rst_action", 512'(action_out), 512'(25'h0));
    checkOutput("lit_026_rst_valid", 512'(action_valid_out), 512'(1'b0));
    idle(4);
    checkOutput("lit_026_no_valid", 512'(action_valid_out), 512'(1'b0));
    applyStimulus(0, 0, 4'b1100, 8'h0F, 1, metaVal(50), 1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu3_action_issuer.md
ALU3_ACTION_ISSUER -- requirements
Module: alu3_action_issuer

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter ACTION_LEN, default 25, action word width.
REQ-003 Parameter META_LEN, default 256, metadata width.
REQ-004 Parameter COMP_LEN, default 100, comparator-instruction width.
REQ-005 Parameter FIFO_DEPTH, default 4 (power of 2, min 2), depth of each pairing FIFO.
REQ-006 Ports SHALL be as follows, one per line:
 clk  in  1  clock; all logic on rising edge
 rst  in  1  synchronous active-high reset
 flush  in  1  synchronous clear of both FIFOs
 req_opcode  in  4  action request opcode
 req_portmap  in  8  multicast port bitmap
 req_valid  in  1  request valid
 req_ready  out  1  request accepted when req_valid && req_ready
 comp_meta_data_in  in  META_LEN+COMP_LEN  metadata + comp_ins from lookup
 comp_meta_data_valid_in  in  1  metadata valid, no backpressure
 action_out  out  ACTION_LEN  action word to ALU
 action_valid_out  out  1  action valid
 comp_meta_data_out  out  META_LEN+COMP_LEN  metadata paired with action_out
 comp_meta_data_valid_out  out  1  metadata valid
 meta_drop_cnt  out  16  metadata beats dropped on full FIFO
 pair_cnt  out  16  pairs issued

Function
REQ-007 Accepted requests SHALL push into action FIFO; valid metadata beats SHALL push into metadata FIFO.
REQ-008 req_ready SHALL be 1 iff action FIFO occupancy < FIFO_DEPTH at cycle start (registered, no combinational path from pop).
REQ-009 Encoding: opcode 4'b1100 -> {1100, req_portmap, 1'b0, 12'b0}; opcode 4'b1101 -> {1101, 8'b0, 1'b1, 12'b0}; any other opcode -> all-zero action (no-op).
REQ-010 When both FIFOs are non-empty, both heads SHALL pop in the same cycle and appear registered on the outputs the next cycle with action_valid_out and comp_meta_data_valid_out both 1 for exactly one cycle.
REQ-011 Latency: 1 cycle from the cycle both heads are available to outputs valid; throughput one pair per cycle.
REQ-012 When no pair is popped, both valid outputs SHALL be 0 and data outputs SHALL hold their last values.
REQ-013 Pairing order SHALL be strict FIFO on both sides; the Nth accepted request pairs with the Nth accepted metadata beat.
REQ-014 Metadata FIFO full with comp_meta_data_valid_in=1: beat accepted if a pop occurs the same cycle, otherwise dropped and meta_drop_cnt incremented.
REQ-015 Simultaneous push and pop on either FIFO SHALL leave occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 flush=1 SHALL empty both FIFOs, suppress any pop that cycle, and drive both valid outputs 0 next cycle; inputs that cycle are discarded; counters unaffected.
REQ-017 Counters SHALL saturate at 16'hFFFF; pair_cnt increments on each pop.

Reset
REQ-018 rst=1 SHALL clear both FIFOs, set req_ready 0 during reset and 1 the cycle after release, and drive all outputs and counters to 0.
REQ-019 rst mid-operation SHALL discard all queued requests and metadata with no further valid outputs.

Configuration
REQ-020 With ALU3_ISSUER_STATS_EN defined, meta_drop_cnt and pair_cnt SHALL behave per REQ-014/REQ-017; without it both SHALL be constant 0 with no counter logic.

Verification
REQ-021 Request opcode 1100 portmap 8'hFF, one all-zero metadata beat same cycle -> next cycle action_out={1100,FF,0,12'h000}, both valids 1 for one cycle.
REQ-022 Request opcode 1101, metadata 3 cycles later -> action_out={1101,00,1,000} paired 1 cycle after metadata arrives, no earlier valid.
REQ-023 Opcode 4'b0011 -> action_out all zero, valids 1.
REQ-024 Five metadata beats without requests (depth 4) -> meta_drop_cnt=1 (STATS_EN); then 5 requests yield 4 pairs in order, 1 request left queued.
REQ-025 Fill action FIFO with 4 requests -> req_ready 0; assert flush -> no outputs, req_ready 1 next cycle, occupancy 0.
REQ-026 rst asserted with 2 pairs pending -> all outputs 0, no valid after release until new inputs.
